// File: rtl/sram_like_arb_pkg.sv
// Shared types and constants for the two-channel SRAM-like arbiter.
// Purely declarative: no logic, no latency, no backpressure.
package sram_like_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ADDR      = 2'd1,
        WAIT_DATA = 2'd2
    } state_e;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/arb2_grant.sv
// Two-way winner select between instruction and data requests (SRAM_LIKE_ARB_RR_EN: round-robin).
// Latency: purely combinational.
// Backpressure: none; the caller decides when the winner is committed.
module arb2_grant (
    input  logic inst_req,
    input  logic data_req,
    input  logic last_owner,
    output logic winner
);
    import sram_like_arb_pkg::*;

`ifdef SRAM_LIKE_ARB_RR_EN
    always_comb begin
        winner = OWN_INST;
        if (inst_req && data_req) begin
            winner = (last_owner == OWN_INST) ? OWN_DATA : OWN_INST;
        end else if (data_req) begin
            winner = OWN_DATA;
        end
    end
`else
    logic unused_last_owner;
    assign unused_last_owner = last_owner;

    always_comb begin
        winner = OWN_INST;
        if (data_req) begin
            winner = OWN_DATA;
        end
    end
`endif

endmodule

// File: rtl/sram_like_arbiter.sv
// Merges inst/data SRAM-like masters onto one port, one transaction in flight (SRAM_LIKE_ARB_RR_EN: round-robin).
// Latency: zero added cycles; request, addr_ok and data_ok pass straight through to the owner.
// Backpressure: the loser sees addr_ok=0 until the owner's data_ok; no preemption once granted.
module sram_like_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req,
    input  logic              inst_wr,
    input  logic [1:0]        inst_size,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [DATA_W-1:0] inst_wdata,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,
    output logic              m_req,
    output logic              m_wr,
    output logic [1:0]        m_size,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_addr_ok,
    input  logic              m_data_ok,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              busy
);
    import sram_like_arb_pkg::*;

    state_e state_q, state_d;
    logic   owner_q, owner_d;
    logic   last_owner;
    logic   winner;
    logic   sel;
    logic   grant;

`ifdef SRAM_LIKE_ARB_RR_EN
    logic last_owner_q, last_owner_d;

    always_comb begin
        last_owner_d = last_owner_q;
        if (grant) begin
            last_owner_d = sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_owner_q <= OWN_INST;
        end else begin
            last_owner_q <= last_owner_d;
        end
    end

    assign last_owner = last_owner_q;
`else
    assign last_owner = OWN_INST;
`endif

    arb2_grant u_grant (
        .inst_req   (inst_req),
        .data_req   (data_req),
        .last_owner (last_owner),
        .winner     (winner)
    );

    // Free choice only in IDLE; afterwards the registered owner holds the port.
    assign sel = (state_q == IDLE) ? winner : owner_q;

    assign inst_rdata = m_rdata;
    assign data_rdata = m_rdata;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        grant        = 1'b0;
        m_req        = 1'b0;
        m_wr         = 1'b0;
        m_size       = '0;
        m_addr       = '0;
        m_wdata      = '0;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
        busy         = 1'b0;

        // Outputs are forced quiet during reset so a pending data_ok cannot escape.
        if (!rst) begin
            busy = (state_q != IDLE);
            case (state_q)
                IDLE, ADDR: begin
                    m_req = (sel == OWN_DATA) ? data_req : inst_req;
                    if (m_req) begin
                        m_wr    = (sel == OWN_DATA) ? data_wr    : inst_wr;
                        m_size  = (sel == OWN_DATA) ? data_size  : inst_size;
                        m_addr  = (sel == OWN_DATA) ? data_addr  : inst_addr;
                        m_wdata = (sel == OWN_DATA) ? data_wdata : inst_wdata;
                        if (state_q == IDLE) begin
                            owner_d = sel;
                            grant   = 1'b1;
                            state_d = ADDR;
                        end
                        if (m_addr_ok) begin
                            inst_addr_ok = (sel == OWN_INST);
                            data_addr_ok = (sel == OWN_DATA);
                            state_d      = WAIT_DATA;
                        end
                    end
                end
                WAIT_DATA: begin
                    if (m_data_ok) begin
                        inst_data_ok = (owner_q == OWN_INST);
                        data_data_ok = (owner_q == OWN_DATA);
                        state_d      = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= OWN_INST;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter with a data_ok scoreboard (SRAM_LIKE_ARB_RR_EN aware).
module tb_sram_like_arbiter;
    import sram_like_arb_pkg::*;

`ifdef SRAM_LIKE_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req, inst_wr, inst_addr_ok, inst_data_ok;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata, inst_rdata;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        m_req, m_wr, m_addr_ok, m_data_ok, busy;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata, m_rdata;

    sram_like_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        ch;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   n_assert  = 0;
    int   n_fail    = 0;
    int   n_inst_ok = 0;
    int   cyc       = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic ch, input logic [31:0] rd);
        exp_t e;
        e.ch    = ch;
        e.rdata = rd;
        sb.push_back(e);
    endtask

    // Let combinational outputs settle, then retire any completion against the scoreboard.
    task automatic settle();
        exp_t e;
        #1;
        if (inst_data_ok || data_data_ok) begin
            chk("sb_pending", 32'(sb.size() != 0), 32'd1);
            chk("sb_both_data_ok", 32'(inst_data_ok & data_data_ok), 32'd0);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_channel", 32'(data_data_ok), 32'(e.ch));
                chk("sb_rdata", e.ch ? data_rdata : inst_rdata, e.rdata);
            end
            if (inst_data_ok) n_inst_ok++;
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // One transaction with immediate addr_ok and data_ok: exactly two cycles.
    task automatic do_xact(input bit inst_on, input bit data_on, input logic exp_ch,
                           input logic [31:0] rd, input string tag);
        inst_req  = inst_on;
        data_req  = data_on;
        m_addr_ok = 1'b1;
        push_exp(exp_ch, rd);
        settle();
        chk({tag, "_m_addr"}, m_addr, (exp_ch == OWN_DATA) ? data_addr : inst_addr);
        chk({tag, "_inst_aok"}, 32'(inst_addr_ok), 32'(exp_ch == OWN_INST));
        chk({tag, "_data_aok"}, 32'(data_addr_ok), 32'(exp_ch == OWN_DATA));
        adv();
        inst_req  = 1'b0;
        data_req  = 1'b0;
        m_addr_ok = 1'b0;
        m_data_ok = 1'b1;
        m_rdata   = rd;
        settle();
        adv();
        m_data_ok = 1'b0;
    endtask

    initial begin
        int c0, k0;
        rst = 1'b1;
        inst_req = 1'b1; inst_wr = 1'b0; inst_size = SIZE_WORD;
        inst_addr = 32'h1FC0_0000; inst_wdata = 32'h0;
        data_req = 1'b0; data_wr = 1'b0; data_size = SIZE_WORD;
        data_addr = 32'h8000_1000; data_wdata = 32'hDEAD_BEEF;
        m_addr_ok = 1'b1; m_data_ok = 1'b0; m_rdata = 32'h0;
        adv();
        adv();
        settle();
        chk("rst_m_req", 32'(m_req), 32'd0);
        chk("rst_m_addr", m_addr, 32'd0);
        chk("rst_inst_aok", 32'(inst_addr_ok), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0; inst_req = 1'b0; m_addr_ok = 1'b0;
        adv();

        // 1: single instruction read, data_ok two cycles after the address.
        inst_req = 1'b1; m_addr_ok = 1'b1;
        push_exp(OWN_INST, 32'h3C00_0001);
        settle();
        chk("t1_inst_aok", 32'(inst_addr_ok), 32'd1);
        chk("t1_m_addr", m_addr, 32'h1FC0_0000);
        chk("t1_busy_c0", 32'(busy), 32'd0);
        adv();
        inst_req = 1'b0; m_addr_ok = 1'b0;
        settle();
        chk("t1_busy_c1", 32'(busy), 32'd1);
        chk("t1_m_req_wait", 32'(m_req), 32'd0);
        adv();
        m_data_ok = 1'b1; m_rdata = 32'h3C00_0001;
        settle();
        chk("t1_inst_dok", 32'(inst_data_ok), 32'd1);
        chk("t1_data_dok", 32'(data_data_ok), 32'd0);
        chk("t1_busy_c2", 32'(busy), 32'd1);
        adv();
        m_data_ok = 1'b0;
        settle();
        chk("t1_busy_c3", 32'(busy), 32'd0);

        // 2: simultaneous requests; the data store goes first, inst waits for its data_ok.
        inst_addr = 32'h1FC0_0004; data_wr = 1'b1;
        inst_req = 1'b1; data_req = 1'b1; m_addr_ok = 1'b1;
        push_exp(OWN_DATA, 32'h1111_1111);
        settle();
        chk("t2_m_addr", m_addr, 32'h8000_1000);
        chk("t2_m_wr", 32'(m_wr), 32'd1);
        chk("t2_m_wdata", m_wdata, 32'hDEAD_BEEF);
        chk("t2_m_size", 32'(m_size), 32'(SIZE_WORD));
        chk("t2_data_aok", 32'(data_addr_ok), 32'd1);
        chk("t2_inst_aok", 32'(inst_addr_ok), 32'd0);
        adv();
        data_req = 1'b0; m_addr_ok = 1'b1;
        settle();
        chk("t2_inst_blocked", 32'(inst_addr_ok), 32'd0);
        adv();
        m_addr_ok = 1'b0; m_data_ok = 1'b1; m_rdata = 32'h1111_1111;
        settle();
        chk("t2_data_dok", 32'(data_data_ok), 32'd1);
        adv();
        m_data_ok = 1'b0; m_addr_ok = 1'b1;
        push_exp(OWN_INST, 32'h2222_2222);
        settle();
        chk("t2_inst_aok_after", 32'(inst_addr_ok), 32'd1);
        chk("t2_m_addr_inst", m_addr, 32'h1FC0_0004);
        chk("t2_m_wr_inst", 32'(m_wr), 32'd0);
        adv();
        inst_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b1; m_rdata = 32'h2222_2222;
        settle();
        adv();
        m_data_ok = 1'b0; data_wr = 1'b0;

        // 2b: after a data-only grant, the next collision depends on the arbitration mode.
        do_xact(1'b0, 1'b1, OWN_DATA, 32'h3333_3333, "t2b_solo");
        do_xact(1'b1, 1'b1, RR ? OWN_INST : OWN_DATA, 32'h4444_4444, "t2b_coll");

        // 3: inst locked in ADDR; data cannot preempt; owner drop and stray addr_ok ignored.
        inst_addr = 32'h1FC0_0100;
        inst_req = 1'b1;
        settle();
        chk("t3_c0_inst_aok", 32'(inst_addr_ok), 32'd0);
        adv();
        data_req = 1'b1;
        settle();
        chk("t3_c1_m_addr", m_addr, 32'h1FC0_0100);
        chk("t3_c1_data_aok", 32'(data_addr_ok), 32'd0);
        adv();
        inst_req = 1'b0; m_addr_ok = 1'b1;
        settle();
        chk("t3_drop_m_req", 32'(m_req), 32'd0);
        chk("t3_drop_data_aok", 32'(data_addr_ok), 32'd0);
        chk("t3_drop_busy", 32'(busy), 32'd1);
        adv();
        inst_req = 1'b1; m_addr_ok = 1'b0;
        settle();
        chk("t3_still_addr", m_addr, 32'h1FC0_0100);
        adv();
        m_addr_ok = 1'b1;
        push_exp(OWN_INST, 32'h5555_5555);
        settle();
        chk("t3_inst_aok", 32'(inst_addr_ok), 32'd1);
        chk("t3_data_aok", 32'(data_addr_ok), 32'd0);
        adv();
        inst_req = 1'b0;
        settle();
        chk("t3_wait_data_aok", 32'(data_addr_ok), 32'd0);
        adv();
        m_addr_ok = 1'b0; m_data_ok = 1'b1; m_rdata = 32'h5555_5555;
        settle();
        chk("t3_inst_dok", 32'(inst_data_ok), 32'd1);
        chk("t3_dok_data_aok", 32'(data_addr_ok), 32'd0);
        adv();
        m_data_ok = 1'b0;
        do_xact(1'b0, 1'b1, OWN_DATA, 32'h6666_6666, "t3_data");

        // 4: stray data_ok while idle.
        m_data_ok = 1'b1; m_rdata = 32'h7777_7777;
        settle();
        chk("t4_inst_dok", 32'(inst_data_ok), 32'd0);
        chk("t4_data_dok", 32'(data_data_ok), 32'd0);
        adv();
        m_data_ok = 1'b0;
        settle();
        chk("t4_busy", 32'(busy), 32'd0);

        // 5: reset in WAIT_DATA abandons the transaction; the late data_ok is dropped.
        inst_req = 1'b1; m_addr_ok = 1'b1;
        push_exp(OWN_INST, 32'h8888_8888);
        settle();
        adv();
        inst_req = 1'b0; m_addr_ok = 1'b0;
        settle();
        chk("t5_busy_wait", 32'(busy), 32'd1);
        adv();
        rst = 1'b1;
        settle();
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_m_req", 32'(m_req), 32'd0);
        adv();
        sb.delete();
        rst = 1'b0; m_data_ok = 1'b1; m_rdata = 32'h8888_8888;
        settle();
        chk("t5_inst_dok", 32'(inst_data_ok), 32'd0);
        chk("t5_busy_after", 32'(busy), 32'd0);
        adv();
        m_data_ok = 1'b0;

        // 6: eight back-to-back reads at two cycles each.
        c0 = cyc;
        k0 = n_inst_ok;
        for (int i = 0; i < 8; i++) begin
            inst_addr = 32'h1FC0_0200 + 32'(i * 4);
            do_xact(1'b1, 1'b0, OWN_INST, 32'hA000_0000 + 32'(i), "t6");
        end
        chk("t6_pulses", 32'(n_inst_ok - k0), 32'd8);
        chk("t6_cycles", 32'(cyc - c0), 32'd16);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
- Merges the core's two SRAM-like master channels (instruction and data) onto a single SRAM-like master port.
- Sits between the core's SRAM-to-SRAM-like bridges and the single-port bus adapter that converts to AXI.
- Allows one outstanding transaction at a time.
- Fixed priority: data wins over instruction.

Parameters:
ADDR_W, 32, address width of all channels
DATA_W, 32, read/write data width of all channels

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
inst_req  in  1  instruction channel request
inst_wr  in  1  instruction write flag (normally 0)
inst_size  in  2  instruction transfer size
inst_addr  in  ADDR_W  instruction address
inst_wdata  in  DATA_W  instruction write data
inst_addr_ok  out  1  instruction address accepted
inst_data_ok  out  1  instruction data returned
inst_rdata  out  DATA_W  instruction read data
data_req  in  1  data channel request
data_wr  in  1  data write flag
data_size  in  2  data transfer size
data_addr  in  ADDR_W  data address
data_wdata  in  DATA_W  data write data
data_addr_ok  out  1  data address accepted
data_data_ok  out  1  data completion
data_rdata  out  DATA_W  data read data
m_req  out  1  merged request
m_wr  out  1  merged write flag
m_size  out  2  merged size
m_addr  out  ADDR_W  merged address
m_wdata  out  DATA_W  merged write data
m_addr_ok  in  1  downstream address accepted
m_data_ok  in  1  downstream data done
m_rdata  in  DATA_W  downstream read data
busy  out  1  a transaction is in flight (state != IDLE)

Behaviour:
- Clocking and reset: one clock `clk`; `rst` is synchronous and active-high.
- Reset values:
  - state = IDLE, owner = INST.
  - All `*_addr_ok`, `*_data_ok`, `m_req`, `m_wr` and `busy` are 0 at reset.
  - `m_size`, `m_addr`, `m_wdata` are 0 while `m_req` = 0.
- FSM states: IDLE, ADDR, WAIT_DATA.
- IDLE:
  - Winner is chosen combinationally: `data_req` wins, else `inst_req`.
  - The winner's req/wr/size/addr/wdata drive the m_* outputs in the same cycle (zero added latency).
  - `m_addr_ok` is routed combinationally to the winner's `addr_ok`.
  - If `m_addr_ok` is 1 that cycle: owner <= winner, go to WAIT_DATA.
  - Else, if any request: owner <= winner, go to ADDR.
- ADDR:
  - The grant is locked to the registered owner. No preemption: a `data_req` arriving while INST owns ADDR waits.
  - The owner's signals are forwarded to m_*; the loser sees `addr_ok` = 0.
  - On `m_addr_ok`: go to WAIT_DATA.
  - If the owner drops its req (protocol violation), `m_req` follows it to 0 and the arbiter stays in ADDR.
- WAIT_DATA:
  - `m_req` = 0; neither requester gets `addr_ok`.
  - On `m_data_ok`: owner's `data_ok` = 1 in the same cycle, go to IDLE.
  - A new grant becomes possible on the following cycle.
- Read data: `inst_rdata` = `data_rdata` = `m_rdata` (broadcast). Only the owner's `data_ok` qualifies it.
- Stray handshakes: `m_data_ok` in IDLE or ADDR is ignored and never routed. `m_addr_ok` while `m_req` = 0 is ignored.
- Minimum back-to-back spacing: 2 cycles per transaction when `addr_ok` and `data_ok` are each immediate.
- Reset mid-transaction: abandon the transaction, go to IDLE, suppress all `data_ok`.

Optional Feature:
- Macro: SRAM_LIKE_ARB_RR_EN.
- Defined: round-robin between the two channels. A `last_owner` register (reset INST) is updated at each grant. When both channels request in IDLE, the channel that is not `last_owner` wins.
- Undefined: fixed data priority as described above; `last_owner` is not instantiated.

Decomposition:
- Shared package sram_like_arb_pkg:
  - state enum: IDLE = 2'd0, ADDR = 2'd1, WAIT_DATA = 2'd2
  - owner constants: OWN_INST = 1'b0, OWN_DATA = 1'b1
  - SIZE_BYTE/HALF/WORD = 2'd0/1/2
- Sub-module arb2_grant: combinational 2-way winner select. It takes the requests plus `last_owner` and returns the winner. It contains the RR ifdef so the main FSM stays priority-agnostic.

Test Plan:
1. Single inst read, `m_addr_ok` same cycle, `m_data_ok` 2 cycles later with `m_rdata` = 0x3C000001 -> `inst_addr_ok` at cycle 0; `inst_data_ok` = 1 at cycle 2 with `inst_rdata` = 0x3C000001; `data_data_ok` stays 0; `busy` 1 for cycles 1-2.
2. `inst_req` and `data_req` both raised at cycle 0 (data store: addr 0x80001000, wdata 0xDEADBEEF, size 2) -> `m_addr` = 0x80001000 and `m_wr` = 1 first. Inst is granted only after `data_data_ok`. With SRAM_LIKE_ARB_RR_EN and `last_owner` = INST, data also wins; on the next collision inst wins.
3. Inst in ADDR (`m_addr_ok` held 0 for 3 cycles) while `data_req` rises at cycle 1 -> `m_addr` stays at the inst address; `data_addr_ok` stays 0 until the inst `data_ok` completes.
4. `m_data_ok` pulse while IDLE, no requests -> no `inst_data_ok` or `data_data_ok`; state stays IDLE.
5. `rst` asserted in WAIT_DATA, then `m_data_ok` asserted the cycle after -> all outputs 0, state IDLE, `data_ok` suppressed.
6. 8 back-to-back inst reads with immediate `m_addr_ok` and `m_data_ok` -> each completes in 2 cycles; 8 `inst_data_ok` pulses within 16 cycles.
